wpa2_mem_burst_reader: RTL and testbench
========================================

Name: wpa2_mem_burst_reader

Overview:
- Avalon-MM initiator for the 4096x32 single-port on-chip memory.
- Accepts a command (base word address, word count) and issues consecutive reads.
- Returns the read words as a valid/ready word stream with a last marker.
- Feeds memory-resident message blocks (e.g. 16-word SHA-1 blocks) into the hash datapath without processor involvement.

Parameters:
- ADDR_W, 12, word-address width; matches the memory depth of 4096.
- LEN_W, 8, command length width; maximum 255 words per command.
- READ_LATENCY, 1, cycles from address presentation to valid m_readdata; the memory registers its address internally.
- FIFO_DEPTH, READ_LATENCY+1, output buffer entries; must be at least READ_LATENCY+1.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  starting word address.
- cmd_len  in  LEN_W  number of words to read.
- m_address  out  ADDR_W  memory word address.
- m_chipselect  out  1  high in each read-issue cycle.
- m_write  out  1  tied 0.
- m_byteenable  out  4  tied 4'hF.
- m_clken  out  1  tied 1.
- m_readdata  in  32  memory read data.
- out_data  out  32  stream word.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accept.
- out_last  out  1  marks the final word of a command.
- busy  out  1  high from command accept until the last word is accepted.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset values: cmd_ready=1 after reset; m_address=0, m_chipselect=0, out_valid=0, out_last=0, busy=0, done=0. FIFO, credit counter and state are cleared.
- The reset is asynchronous. Asserting it mid-command drops that command immediately, including in-flight reads and buffered words. No done pulse is generated.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_valid&cmd_ready latches the address into m_address and loads remaining=cmd_len.
  - If cmd_len==0: go directly to IDLE-with-done; done pulses on the next cycle, no memory access, no stream output.
  - Otherwise go to ISSUE and set busy=1.
- ISSUE:
  - A read is issued (m_chipselect=1) when remaining!=0 and inflight+fifo_count < FIFO_DEPTH.
  - The credit check counts the FIFO pop occurring in the same cycle.
  - Each issue increments m_address and decrements remaining.
  - m_address wraps modulo 2^ADDR_W: 4095 -> 0.
  - When the last read is issued, go to DRAIN.
- Return path:
  - A READ_LATENCY-deep shift register of issue flags tags returning data.
  - Tagged m_readdata is pushed into the FIFO.
  - Under the credit rule the FIFO never overflows and no read data is lost.
- Stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A word transfers on out_valid&out_ready.
  - out_data and out_valid stay stable while out_valid&!out_ready.
  - out_last=1 on the word whose transfer count equals cmd_len.
- DRAIN: when the last word transfers, return to IDLE; busy drops and done pulses in the next cycle.
- Throughput: with out_ready held high, one word per cycle. The first out_valid appears READ_LATENCY+1 cycles after command accept.
- m_write is constant 0 in all states; this block never writes memory.

Optional Feature:
- Macro: WPA2_RD_BYTESWAP_EN.
- Defined: out_data is byte-reversed ({b0,b1,b2,b3}) so that little-endian memory words present big-endian to the SHA-1 core. Swapping is applied at the FIFO output.
- Undefined: out_data equals m_readdata unchanged.
- Timing and handshake are identical in both builds.

Decomposition:
- Package wpa2_rd_pkg holds:
  - the FSM state typedef (IDLE, ISSUE, DRAIN);
  - ADDR_W and LEN_W defaults;
  - the SHA1_BLOCK_WORDS=16 constant.
- Sub-module wpa2_rd_fifo: a small synchronous FIFO (FIFO_DEPTH entries, with count output, same clk/reset_n). The top level holds the FSM, credit logic and latency tagging.

Test Plan:
- Memory preloaded word[i]=i; cmd_addr=0x010, cmd_len=16, out_ready=1 -> words 0x10..0x1F on consecutive cycles, out_last on 0x1F, done pulses once, busy low afterwards.
- cmd_addr=0xFFE, cmd_len=4 -> addresses 0xFFE,0xFFF,0x000,0x001 issued; data matches in order.
- cmd_len=16, out_ready toggled randomly or held low for 10 cycles -> no word lost or duplicated, m_chipselect stalls while the FIFO is full, output stable while stalled.
- cmd_len=0 -> no m_chipselect, no out_valid, done pulse one cycle after accept.
- reset_n asserted after 5 of 16 words -> all outputs return to reset values immediately; a fresh command then completes normally.
- WPA2_RD_BYTESWAP_EN defined, word 0x11223344 -> out_data 0x44332211; undefined -> 0x11223344.

Source files
------------

// File: rtl/wpa2_rd_pkg.sv
// Shared types and defaults for the WPA2 memory burst reader.
// The build macro WPA2_RD_BYTESWAP_EN is consumed in wpa2_mem_burst_reader.sv.
package wpa2_rd_pkg;

  localparam int DEF_ADDR_W       = 12;
  localparam int DEF_LEN_W        = 8;
  localparam int SHA1_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/wpa2_rd_fifo.sv
// Small first-word-fall-through FIFO holding returned read words.
// Head is visible combinationally; count feeds the issue credit check.
module wpa2_rd_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  // A pop in the same cycle frees the slot a full-FIFO push would use.
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/wpa2_mem_burst_reader.sv
// Avalon-MM burst reader: streams cmd_len consecutive memory words out.
// Define WPA2_RD_BYTESWAP_EN to byte-reverse each word at the FIFO output.
module wpa2_mem_burst_reader
  import wpa2_rd_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = READ_LATENCY + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [31:0]       m_readdata,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  rd_state_t             state_reg, state_next;
  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [LEN_W-1:0]      remaining_reg, remaining_next;
  logic [LEN_W-1:0]      len_reg, len_next;
  logic [LEN_W-1:0]      xfer_reg, xfer_next;
  logic                  done_reg, done_next;
  logic [READ_LATENCY-1:0] tag_reg;
  logic [READ_LATENCY:0]   tag_shift;
  logic [CNT_W-1:0]      fifo_count, inflight;
  logic [OCC_W-1:0]      occupancy;
  logic                  issue, push, pop;
  logic [31:0]           head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(tag_reg[i]);
  end

  // Reads in flight plus buffered words, less this cycle's pop, must leave a free slot.
  assign pop       = out_valid && out_ready;
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = (state_reg == ISSUE) && (remaining_reg != '0)
                     && (occupancy < OCC_W'(FIFO_DEPTH));
  assign tag_shift = {tag_reg, issue};
  assign push      = tag_reg[READ_LATENCY-1];

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    len_next       = len_reg;
    xfer_next      = xfer_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next      = cmd_addr;
          remaining_next = cmd_len;
          len_next       = cmd_len;
          xfer_next      = '0;
          if (cmd_len == '0) done_next  = 1'b1;
          else               state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_next      = addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN:   ;
      default: state_next = IDLE;
    endcase
    if ((state_reg != IDLE) && pop) begin
      xfer_next = xfer_reg + 1'b1;
      if (out_last) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      len_reg       <= '0;
      xfer_reg      <= '0;
      done_reg      <= 1'b0;
      tag_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      len_reg       <= len_next;
      xfer_reg      <= xfer_next;
      done_reg      <= done_next;
      tag_reg       <= tag_shift[READ_LATENCY-1:0];
    end
  end

  wpa2_rd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (m_readdata),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

`ifdef WPA2_RD_BYTESWAP_EN
  assign out_data = {head[7:0], head[15:8], head[23:16], head[31:24]};
`else
  assign out_data = head;
`endif

  assign out_valid    = (fifo_count != '0);
  assign out_last     = out_valid && (xfer_reg == len_reg - 1'b1);
  assign cmd_ready    = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign m_address    = addr_reg;
  assign m_chipselect = issue;
  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;

endmodule

// File: tb/tb_wpa2_mem_burst_reader.sv
// Directed bench for wpa2_mem_burst_reader against a 4096x32 memory model
// with one cycle of registered read latency.
module tb_wpa2_mem_burst_reader;

  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [11:0] m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic        m_clken;
  logic [31:0] m_readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:4095];

  logic [31:0] got_data [0:63];
  logic        got_last [0:63];
  logic [11:0] cs_addr  [0:63];
  int got_n, cs_n, cs_stall_n, first_valid, done_n, done_cyc;
  int stab_err, credit_err;
  logic busy_at_start, busy_at_done;

  wpa2_mem_burst_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_chipselect) m_readdata <= mem[m_address];
  end

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef WPA2_RD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Drives one command and records what the DUT does; region k is the half
  // cycle after the k-th rising edge following the accept edge.
  task automatic run_cmd(input logic [11:0] a, input logic [7:0] l, input int mode);
    logic        prev_hold;
    logic [31:0] prev_data;
    got_n = 0; cs_n = 0; cs_stall_n = 0; first_valid = -1; done_n = 0;
    done_cyc = -1; stab_err = 0; credit_err = 0; busy_at_start = 1'b0;
    busy_at_done = 1'b1; prev_hold = 1'b0; prev_data = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k >= 10);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (k == 0) busy_at_start = busy;
      if (prev_hold && (!out_valid || out_data !== prev_data)) stab_err++;
      if (out_valid && first_valid < 0) first_valid = k;
      if (m_chipselect) begin
        if (cs_n - got_n - int'(out_valid && out_ready) >= FIFO_DEPTH) credit_err++;
        if (cs_n < 64) cs_addr[cs_n] = m_address;
        cs_n++;
        if (k < 10) cs_stall_n++;
      end
      if (out_valid && out_ready) begin
        if (got_n < 64) begin
          got_data[got_n] = out_data;
          got_last[got_n] = out_last;
        end
        got_n++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc     = k;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    total++; if (m_address !== 12'h000) begin bad++; $display("FAIL reset_m_address got %h want 000", m_address); end
    total++; if (m_chipselect !== 1'b0) begin bad++; $display("FAIL reset_chipselect got %b want 0", m_chipselect); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got %b want 0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if ({m_write, m_byteenable, m_clken} !== 6'b0_1111_1) begin
      bad++; $display("FAIL reset_ties got %b want 011111", {m_write, m_byteenable, m_clken});
    end
    $display("reset: cmd_ready=%b busy=%b out_valid=%b", cmd_ready, busy, out_valid);
  endtask

  task automatic test_basic();
    run_cmd(12'h010, 8'd16, 0);
    total++; if (got_n !== 16) begin bad++; $display("FAIL basic_count got %0d want 16", got_n); end
    for (int i = 0; i < 16 && i < got_n; i++) begin
      total++; if (got_data[i] !== exp_word(32'h10 + 32'(i))) begin
        bad++; $display("FAIL basic_data[%0d] got %h want %h", i, got_data[i], exp_word(32'h10 + 32'(i)));
      end
      total++; if (got_last[i] !== (i == 15)) begin
        bad++; $display("FAIL basic_last[%0d] got %b want %b", i, got_last[i], i == 15);
      end
    end
    total++; if (first_valid !== 2) begin bad++; $display("FAIL basic_first_valid got %0d want 2", first_valid); end
    total++; if (done_cyc !== 18) begin bad++; $display("FAIL basic_done_cycle got %0d want 18", done_cyc); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL basic_done_pulses got %0d want 1", done_n); end
    total++; if (busy_at_start !== 1'b1) begin bad++; $display("FAIL basic_busy_start got %b want 1", busy_at_start); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_end got %b want 0", busy_at_done); end
    total++; if (cs_n !== 16) begin bad++; $display("FAIL basic_reads got %0d want 16", cs_n); end
    $display("basic: addr=010 len=16 words=%0d first_valid=%0d done_cyc=%0d", got_n, first_valid, done_cyc);
  endtask

  task automatic test_wrap();
    logic [11:0] exp_a [0:3];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    run_cmd(12'hFFE, 8'd4, 0);
    total++; if (cs_n !== 4) begin bad++; $display("FAIL wrap_reads got %0d want 4", cs_n); end
    total++; if (got_n !== 4) begin bad++; $display("FAIL wrap_count got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (cs_addr[i] !== exp_a[i]) begin
        bad++; $display("FAIL wrap_addr[%0d] got %h want %h", i, cs_addr[i], exp_a[i]);
      end
      total++; if (got_data[i] !== exp_word({20'h0, exp_a[i]})) begin
        bad++; $display("FAIL wrap_data[%0d] got %h want %h", i, got_data[i], exp_word({20'h0, exp_a[i]}));
      end
    end
    $display("wrap: addr=ffe len=4 reads=%0d words=%0d", cs_n, got_n);
  endtask

  task automatic test_stall();
    run_cmd(12'h200, 8'd16, 1);
    total++; if (cs_stall_n !== FIFO_DEPTH) begin bad++; $display("FAIL stall_reads_while_held got %0d want %0d", cs_stall_n, FIFO_DEPTH); end
    total++; if (got_n !== 16) begin bad++; $display("FAIL stall_count got %0d want 16", got_n); end
    for (int i = 0; i < 16 && i < got_n; i++) begin
      total++; if (got_data[i] !== exp_word(32'h200 + 32'(i))) begin
        bad++; $display("FAIL stall_data[%0d] got %h want %h", i, got_data[i], exp_word(32'h200 + 32'(i)));
      end
    end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL stall_stability got %0d want 0", stab_err); end
    total++; if (credit_err !== 0) begin bad++; $display("FAIL stall_credit got %0d want 0", credit_err); end
    $display("stall: held 10 cycles reads_during_hold=%0d words=%0d", cs_stall_n, got_n);
  endtask

  task automatic test_random_ready();
    run_cmd(12'h300, 8'd16, 2);
    total++; if (got_n !== 16) begin bad++; $display("FAIL random_count got %0d want 16", got_n); end
    for (int i = 0; i < 16 && i < got_n; i++) begin
      total++; if (got_data[i] !== exp_word(32'h300 + 32'(i))) begin
        bad++; $display("FAIL random_data[%0d] got %h want %h", i, got_data[i], exp_word(32'h300 + 32'(i)));
      end
    end
    total++; if (got_last[15] !== 1'b1) begin bad++; $display("FAIL random_last got %b want 1", got_last[15]); end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL random_stability got %0d want 0", stab_err); end
    total++; if (credit_err !== 0) begin bad++; $display("FAIL random_credit got %0d want 0", credit_err); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL random_done_pulses got %0d want 1", done_n); end
    $display("random: words=%0d done_cyc=%0d", got_n, done_cyc);
  endtask

  task automatic test_zero_len();
    run_cmd(12'h020, 8'd0, 0);
    total++; if (cs_n !== 0) begin bad++; $display("FAIL zero_reads got %0d want 0", cs_n); end
    total++; if (first_valid !== -1) begin bad++; $display("FAIL zero_out_valid got %0d want -1", first_valid); end
    total++; if (done_cyc !== 0) begin bad++; $display("FAIL zero_done_cycle got %0d want 0", done_cyc); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL zero_done_pulses got %0d want 1", done_n); end
    total++; if (busy_at_start !== 1'b0) begin bad++; $display("FAIL zero_busy got %b want 0", busy_at_start); end
    $display("zero_len: reads=%0d done_cyc=%0d", cs_n, done_cyc);
  endtask

  task automatic test_reset_mid();
    int n;
    int late_done;
    n = 0; late_done = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 12'h040; cmd_len = 8'd16; out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
      #1;
      if (out_valid && out_ready) n++;
    end
    total++; if (n !== 5) begin bad++; $display("FAIL midreset_prefix got %0d want 5", n); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got %b want 0", busy); end
    total++; if (m_chipselect !== 1'b0) begin bad++; $display("FAIL midreset_chipselect got %b want 0", m_chipselect); end
    total++; if (m_address !== 12'h000) begin bad++; $display("FAIL midreset_m_address got %h want 000", m_address); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midreset_cmd_ready got %b want 1", cmd_ready); end
    total++; if ({out_last, done} !== 2'b00) begin bad++; $display("FAIL midreset_last_done got %b want 00", {out_last, done}); end
    @(negedge clk); reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      if (done || out_valid) late_done++;
    end
    total++; if (late_done !== 0) begin bad++; $display("FAIL midreset_residue got %0d want 0", late_done); end
    $display("midreset: aborted after %0d words", n);
    run_cmd(12'h040, 8'd16, 0);
    total++; if (got_n !== 16) begin bad++; $display("FAIL midreset_fresh_count got %0d want 16", got_n); end
    total++; if (got_data[0] !== exp_word(32'h40)) begin bad++; $display("FAIL midreset_fresh_first got %h want %h", got_data[0], exp_word(32'h40)); end
    total++; if (got_data[15] !== exp_word(32'h4F)) begin bad++; $display("FAIL midreset_fresh_last_word got %h want %h", got_data[15], exp_word(32'h4F)); end
    total++; if (done_n !== 1) begin bad++; $display("FAIL midreset_fresh_done got %0d want 1", done_n); end
    $display("midreset: fresh command words=%0d done_cyc=%0d", got_n, done_cyc);
  endtask

  task automatic test_byteswap();
    logic [31:0] want;
`ifdef WPA2_RD_BYTESWAP_EN
    want = 32'h44332211;
`else
    want = 32'h11223344;
`endif
    run_cmd(12'h100, 8'd1, 0);
    total++; if (got_n !== 1) begin bad++; $display("FAIL swap_count got %0d want 1", got_n); end
    total++; if (got_data[0] !== want) begin bad++; $display("FAIL swap_data got %h want %h", got_data[0], want); end
    total++; if (got_last[0] !== 1'b1) begin bad++; $display("FAIL swap_last got %b want 1", got_last[0]); end
    $display("byteswap: out_data=%h", got_data[0]);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    mem[12'h100] = 32'h11223344;
    m_readdata = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_random_ready();
    test_zero_len();
    test_reset_mid();
    test_byteswap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
